phase_timer_ctrl: RTL
=====================

Name: phase_timer_ctrl

Overview:
- Initiator side of the countdown-timer interface (counterSeconds / start / signal).
- Accepts a phase request, drives the duration and a one-cycle start pulse into the countdown counter, then waits for expiry and reports completion.
- Supports single phases and a chained three-phase sequence.
- Sits between the top-level controller FSM and the 1 Hz countdown counter, in the same 1 Hz clock domain.

Parameters:
- T_PH0, 300, duration of phase 0 in seconds (5 min).
- T_PH1, 420, duration of phase 1 in seconds (7 min).
- T_PH2, 480, duration of phase 2 in seconds (8 min).
- All three are 10-bit values, 0..1023.

Ports:
- clk  in  1  1 Hz system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request; sampled only in IDLE.
- phase  in  2  selects the phase: 0/1/2 = single phase, 3 = chained sequence 0→1→2.
- abort  in  1  cancels any run in progress.
- signal  in  1  expiry flag from the counter (1 = count is zero).
- counterSeconds  out  10  duration presented to the counter.
- start  out  1  one-cycle load pulse to the counter.
- busy  out  1  high from the cycle after req is accepted until return to IDLE.
- phase_active  out  2  index of the phase currently timing.
- done  out  1  one-cycle pulse when a run completes normally.
- aborted  out  1  one-cycle pulse when a run is cancelled.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- All outputs are registered (Moore).
- Reset values: start=0, counterSeconds=0, busy=0, phase_active=0, done=0, aborted=0, state=IDLE.
- Asserting reset mid-run returns to IDLE immediately; no done or aborted pulse is generated.
- States: IDLE, LOAD, ARM, WAIT, NEXT, DONE.
- IDLE:
  - On req=1 and abort=0 at an edge: latch seq = (phase==3), set phase_active to (phase==3 ? 0 : phase), go to LOAD.
  - req while not in IDLE is ignored.
- LOAD:
  - start=1 for exactly this cycle.
  - counterSeconds = T_PHx for phase_active.
  - Next state is ARM.
- ARM:
  - signal is ignored for this one cycle; it still reflects the previous count.
  - Next state is WAIT.
- WAIT:
  - On signal=1, go to NEXT if seq and phase_active<2, else go to DONE.
- NEXT:
  - phase_active += 1, then go to LOAD.
  - NEXT to LOAD adds one cycle of gap between phases.
- DONE:
  - done=1 for one cycle, busy drops the same cycle, next state IDLE.
- Latency: with start sampled by the counter at edge E, WAIT sees expiry and enters DONE/NEXT at edge E+N+1 for N≥1, and E+2 for N=0.
  - N=0 is legal: the counter never leaves zero, and the ARM state guarantees a clean completion.
- busy timing: asserted from the LOAD cycle, i.e. the first cycle after the req edge, through the DONE cycle.
- counterSeconds is held stable from LOAD until the next LOAD or IDLE.
  - In IDLE it keeps its last value; it is not cleared.
- Abort:
  - abort=1 in any state other than IDLE: next state IDLE, aborted=1 for one cycle, done=0, start=0.
  - The counter is left running, and its signal is ignored thereafter.
  - abort together with req in IDLE: abort wins; no start, no aborted pulse.
  - abort in DONE: the done pulse already issued stands; no aborted pulse.
- start is never asserted in two consecutive cycles.
- phase_active is stable throughout a phase.

Decomposition:
- Shared package (timer_pkg):
  - State enum (IDLE, LOAD, ARM, WAIT, NEXT, DONE).
  - Phase codes PH0=0, PH1=1, PH2=2, PH_SEQ=3.
  - Width constant SEC_W=10.
  - Default durations 300/420/480.
- One natural sub-module: phase_duration_lut.
  - Combinational map from phase_active to 10-bit seconds, driven by the T_PHx parameters.
- The FSM and output registers stay in phase_timer_ctrl.
- The bench instantiates the existing countdown counter as the responder.

Test Plan:
- Reset then req=1, phase=0, with T_PH0 overridden to 3 → start is high exactly one cycle with counterSeconds=3; done pulses at edge E+4; busy is high for 6 cycles.
- phase=3 with T_PH*=2,1,0 → three start pulses carrying 2, 1, 0; phase_active steps 0→1→2; exactly one done at the end.
- T_PH1=0 single run → done at E+2; no hang while signal stays high throughout.
- abort asserted in WAIT mid-count → aborted pulses once, busy=0 next cycle, no done; a new req 1 cycle later restarts with a fresh start pulse.
- req and abort in the same IDLE cycle → no start, no aborted, busy stays 0; req during WAIT is ignored (no extra start pulse).
- reset pulled low asynchronously between edges in ARM → all outputs 0 immediately; after reset release, IDLE accepts req normally.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the phase timer initiator.
package timer_pkg;

    localparam int SEC_W = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ARM  = 3'd2,
        WAIT = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [1:0] PH0    = 2'd0;
    localparam logic [1:0] PH1    = 2'd1;
    localparam logic [1:0] PH2    = 2'd2;
    localparam logic [1:0] PH_SEQ = 2'd3;

    localparam logic [SEC_W-1:0] DEF_T_PH0 = 10'd300;
    localparam logic [SEC_W-1:0] DEF_T_PH1 = 10'd420;
    localparam logic [SEC_W-1:0] DEF_T_PH2 = 10'd480;

    // True when the given phase is the final one of a chained sequence.
    function automatic logic is_last_phase(input logic [1:0] pa);
        return (pa == PH2);
    endfunction

endpackage

// File: rtl/phase_duration_lut.sv
// Combinational map from phase index to its duration in seconds.
module phase_duration_lut
    import timer_pkg::*;
#(
    parameter logic [SEC_W-1:0] T_PH0 = DEF_T_PH0,
    parameter logic [SEC_W-1:0] T_PH1 = DEF_T_PH1,
    parameter logic [SEC_W-1:0] T_PH2 = DEF_T_PH2
) (
    input  logic [1:0]       phase_sel,
    output logic [SEC_W-1:0] seconds
);

    // Select the duration for the requested phase; the sequence code never reaches here.
    always_comb begin
        seconds = {SEC_W{1'b0}};
        case (phase_sel)
            PH0:     seconds = T_PH0;
            PH1:     seconds = T_PH1;
            PH2:     seconds = T_PH2;
            default: seconds = {SEC_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/phase_timer_ctrl.sv
// Initiator side of the countdown-timer handshake: loads a duration, pulses
// start, waits for expiry and reports done/aborted. Supports a chained
// three-phase sequence. All outputs are registered from the next state.
module phase_timer_ctrl
    import timer_pkg::*;
#(
    parameter logic [SEC_W-1:0] T_PH0 = DEF_T_PH0,
    parameter logic [SEC_W-1:0] T_PH1 = DEF_T_PH1,
    parameter logic [SEC_W-1:0] T_PH2 = DEF_T_PH2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [1:0]       phase,
    input  logic             abort,
    input  logic             signal,
    output logic [SEC_W-1:0] counterSeconds,
    output logic             start,
    output logic             busy,
    output logic [1:0]       phase_active,
    output logic             done,
    output logic             aborted
);

    state_t           state_q, state_d;
    logic             seq_q, seq_d;
    logic [1:0]       phase_active_q, phase_active_d;
    logic [SEC_W-1:0] cnt_sec_q, cnt_sec_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [SEC_W-1:0] lut_sec_s;

    // Duration for the phase about to be loaded (looked up from the next index).
    phase_duration_lut #(
        .T_PH0 (T_PH0),
        .T_PH1 (T_PH1),
        .T_PH2 (T_PH2)
    ) u_lut (
        .phase_sel (phase_active_d),
        .seconds   (lut_sec_s)
    );

    // Next-state and next-output logic; outputs derive from the next state so they register cleanly.
    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        phase_active_d = phase_active_q;
        cnt_sec_d      = cnt_sec_q;
        aborted_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req && !abort) begin
                    seq_d          = (phase == PH_SEQ);
                    phase_active_d = (phase == PH_SEQ) ? PH0 : phase;
                    state_d        = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD:    state_d = ARM;
            // Counter has just been loaded; its expiry flag is not yet trustworthy.
            ARM:     state_d = WAIT;
            WAIT: begin
                if (signal) begin
                    if (seq_q && !is_last_phase(phase_active_q)) begin
                        state_d = NEXT;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            NEXT: begin
                phase_active_d = phase_active_q + 2'd1;
                state_d        = LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort cancels any run; a completed run (DONE) keeps its done pulse instead.
        if (abort && (state_q != IDLE) && (state_q != DONE)) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            aborted_d = 1'b0;
        end

        if (state_d == LOAD) begin
            cnt_sec_d = lut_sec_s;
        end else begin
            cnt_sec_d = cnt_sec_q;
        end

        start_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            seq_q          <= 1'b0;
            phase_active_q <= 2'd0;
            cnt_sec_q      <= {SEC_W{1'b0}};
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            phase_active_q <= phase_active_d;
            cnt_sec_q      <= cnt_sec_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
        end
    end

    assign counterSeconds = cnt_sec_q;
    assign start          = start_q;
    assign busy           = busy_q;
    assign phase_active   = phase_active_q;
    assign done           = done_q;
    assign aborted        = aborted_q;

endmodule
